sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Pointer/flag controller and read-side output stage for a synchronous FIFO built around the team's single-clock FIFO memory (registered write port, combinational read port).
- Accepts writes on a valid/ready handshake and drives the memory write port.
- Reads the memory through a one-entry output register and presents data on a valid/ready read handshake, so downstream logic sees registered data.

Parameters:
- MEM_DEPTH, `CFG_FIFO_DEPTH, number of memory entries (>=2; need not be a power of 2).
- DATA_WIDTH, `CFG_DATA_WIDTH, data width.
- ADDR_WIDTH, $clog2(MEM_DEPTH), memory address width.
- LVL_WIDTH, $clog2(MEM_DEPTH+2), width of level output.
- AFULL_THRESH, MEM_DEPTH-1, level at or above which almost_full asserts.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer has data.
- wr_data  in  DATA_WIDTH  producer data.
- wr_ready  out  1  controller can accept a write.
- rd_valid  out  1  rd_data holds a valid word.
- rd_data  out  DATA_WIDTH  output register contents.
- rd_ready  in  1  consumer takes the word.
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  ADDR_WIDTH  memory write address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_addr  out  ADDR_WIDTH  memory read address (= rd_ptr).
- mem_rd_data  in  DATA_WIDTH  combinational memory read data.
- level  out  LVL_WIDTH  words held (memory + output register).
- almost_full  out  1  level >= AFULL_THRESH.
- overflow_err  out  1  sticky: wr_valid seen while wr_ready=0.

Behaviour:
- **Reset** (reset=1 at posedge): wr_ptr=0, rd_ptr=0, mem_count=0, rd_valid=0, rd_data=0, overflow_err=0. Outputs then read wr_ready=1, level=0, almost_full=0 (unless AFULL_THRESH=0). Reset mid-operation discards all contents; no memory clear is needed.
- **Write accept:** wr_acc = wr_valid & wr_ready. wr_ready = (mem_count < MEM_DEPTH), decoded from registers only, with no combinational path from rd_ready.
  - mem_wr_en = wr_acc, mem_wr_addr = wr_ptr, mem_wr_data = wr_data.
  - On wr_acc, wr_ptr advances by 1 and wraps from MEM_DEPTH-1 to 0.
- **Read consume:** rd_acc = rd_valid & rd_ready.
- **Prefetch:** pf = (mem_count != 0) & (!rd_valid | rd_ready). On pf: rd_data <= mem_rd_data, rd_ptr advances with the same wrap rule, rd_valid <= 1.
- **rd_valid clear:** if rd_acc & !pf, rd_valid <= 0.
- **mem_count update:** mem_count <= mem_count + wr_acc - pf. Simultaneous write and prefetch leaves the count unchanged.
- **Capacity and level:** total capacity is MEM_DEPTH+1 (memory plus output register). level = mem_count + rd_valid, and is registered-derived.
- **Latency:** a word accepted in cycle N is written at the end of cycle N. It is prefetched at the end of N+1 and is visible (rd_valid=1) in cycle N+2. Sustained throughput is 1 word/cycle in each direction.
- **Full:** with mem_count=MEM_DEPTH, wr_ready=0 even if a prefetch occurs that cycle; it rises the following cycle.
- **Empty:** with mem_count=0 and rd_valid=1, rd_acc clears rd_valid. A write in that same cycle does not bypass to the output.
- **rd_data stability:** rd_data holds while rd_valid=1 & rd_ready=0.
- **overflow_err:** set on wr_valid & !wr_ready. Cleared only by reset. The offending write is dropped and no state changes.
- **Invariants:**
  - mem_count never exceeds MEM_DEPTH.
  - rd_ptr == wr_ptr whenever mem_count is 0 or MEM_DEPTH.

Test Plan:
Bench settings: MEM_DEPTH=4, DATA_WIDTH=8, AFULL_THRESH=3.
1. Reset, then write 0xA1 once with rd_ready=0 -> mem_wr_en pulse at addr 0; rd_valid=1, rd_data=0xA1 two cycles after accept; level=1.
2. rd_ready=0, write 0x01..0x06 back-to-back -> five accepted (0x01 in output register, 0x02..0x05 in memory); wr_ready=0 when level=5; 0x06 write sets overflow_err=1; almost_full=1 from level 3.
3. From test 2's full state, rd_ready=1 continuously -> rd_data 0x01,0x02,0x03,0x04,0x05 on consecutive cycles; then rd_valid=0, level=0; wr_ready re-asserts the cycle after the first prefetch.
4. Simultaneous streaming, wr_valid=rd_ready=1 for 20 cycles with an incrementing counter -> output equals input in order, pointers wrap 3->0 repeatedly, level settles to 2 and stays constant.
5. Random wr_valid/rd_ready (50%) for 1000 cycles -> scoreboard match; level equals accepted writes minus reads; overflow_err stays 0 when the producer honours wr_ready.
6. Assert reset with level=4 mid-stream -> next cycle rd_valid=0, level=0, wr_ready=1, overflow_err=0; a new write 0x5A is read out correctly with no stale data.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer/flag controller for a single-clock FIFO memory
// with a one-entry registered output stage on the read side.
// Total capacity is MEM_DEPTH words in memory plus one in the output register.

`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 4
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module sync_fifo_ctrl #(
   parameter int MEM_DEPTH    = `CFG_FIFO_DEPTH,
   parameter int DATA_WIDTH   = `CFG_DATA_WIDTH,
   parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
   parameter int LVL_WIDTH    = $clog2(MEM_DEPTH + 2),
   parameter int AFULL_THRESH = MEM_DEPTH - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_ready,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [LVL_WIDTH-1:0]  level,
   output logic                  almost_full,
   output logic                  overflow_err
);

   localparam logic [LVL_WIDTH-1:0]  DEPTH_L = LVL_WIDTH'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_L  = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [LVL_WIDTH:0]    AFULL_L = (LVL_WIDTH + 1)'(AFULL_THRESH);

   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_WIDTH-1:0]  memCount_q, memCount_d;
   logic                  rdValid_q, rdValid_d;
   logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
   logic                  overflow_q, overflow_d;

   logic wrAcc;
   logic rdAcc;
   logic pf;

   // Pointers wrap explicitly so the depth need not be a power of two.
   function automatic logic [ADDR_WIDTH-1:0] nextPtr(input logic [ADDR_WIDTH-1:0] p);
      if (p == LAST_L) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Handshake decode: wr_ready comes only from the memory count register,
   // so there is no combinational path from rd_ready to wr_ready.
   assign wr_ready = (memCount_q < DEPTH_L);
   assign wrAcc    = wr_valid & wr_ready;
   assign rdAcc    = rdValid_q & rd_ready;
   assign pf       = (memCount_q != '0) & (~rdValid_q | rd_ready);

   assign mem_wr_en    = wrAcc;
   assign mem_wr_addr  = wrPtr_q;
   assign mem_wr_data  = wr_data;
   assign mem_rd_addr  = rdPtr_q;

   assign rd_valid     = rdValid_q;
   assign rd_data      = rdData_q;
   assign overflow_err = overflow_q;
   assign level        = memCount_q + LVL_WIDTH'(rdValid_q);
   assign almost_full  = ({1'b0, level} >= AFULL_L);

   // Next-state logic: pointer advance, count bookkeeping, output-register
   // refill and the sticky overflow flag.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      memCount_d = memCount_q;
      rdValid_d  = rdValid_q;
      rdData_d   = rdData_q;
      overflow_d = overflow_q | (wr_valid & ~wr_ready);

      if (wrAcc) begin
         wrPtr_d = nextPtr(wrPtr_q);
      end

      if (pf) begin
         rdPtr_d   = nextPtr(rdPtr_q);
         rdData_d  = mem_rd_data;
         rdValid_d = 1'b1;
      end else if (rdAcc) begin
         rdValid_d = 1'b0;
      end

      case ({wrAcc, pf})
         2'b10:   memCount_d = memCount_q + 1'b1;
         2'b01:   memCount_d = memCount_q - 1'b1;
         default: memCount_d = memCount_q;
      endcase
   end

   // State registers with synchronous reset; memory contents are not cleared,
   // they simply become unreachable once the pointers and count return to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         memCount_q <= '0;
         rdValid_q  <= 1'b0;
         rdData_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         memCount_q <= memCount_d;
         rdValid_q  <= rdValid_d;
         rdData_q   <= rdData_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed and random stimulus around sync_fifo_ctrl with
// a behavioural FIFO memory and a queue-based scoreboard on the read side.

module tb_sync_fifo_ctrl;

   localparam int MEM_DEPTH  = 4;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 2;
   localparam int LVL_WIDTH  = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_ready;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic [LVL_WIDTH-1:0]  level;
   logic                  almost_full;
   logic                  overflow_err;

   logic [DATA_WIDTH-1:0] memArray [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] expQ [$];
   logic [DATA_WIDTH-1:0] expWord;

   int testsRun    = 0;
   int testsFailed = 0;

   sync_fifo_ctrl #(
      .MEM_DEPTH    (MEM_DEPTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .LVL_WIDTH    (LVL_WIDTH),
      .AFULL_THRESH (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_ready     (rd_ready),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .level        (level),
      .almost_full  (almost_full),
      .overflow_err (overflow_err)
   );

   // Clock generation, 10 time-unit period.
   always #5 clk = ~clk;

   // Behavioural FIFO memory: registered write, combinational read.
   always @(posedge clk) begin
      if (mem_wr_en) begin
         memArray[mem_wr_addr] <= mem_wr_data;
      end
   end
   assign mem_rd_data = memArray[mem_rd_addr];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [DATA_WIDTH-1:0] wd,
                                input logic rr);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Stimulus side of the scoreboard: every accepted write becomes an
   // expected read word.
   always @(negedge clk) begin
      if (!reset && wr_valid && wr_ready) begin
         expQ.push_back(wr_data);
      end
   end

   // Monitor: every consumed output word is compared against the oldest
   // expected word; reset discards whatever was in flight.
   always @(negedge clk) begin
      if (reset) begin
         expQ.delete();
      end else if (rd_valid && rd_ready) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL rd_data_unexpected: got 0x%0h, required no word", rd_data);
         end else begin
            expWord = expQ.pop_front();
            checkOutput("rd_data", 32'(rd_data), 32'(expWord));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [LVL_WIDTH-1:0] expLvl2 [6];
   logic                 expAf2  [6];
   bit                   seen;

   initial begin
      expLvl2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
      expAf2  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      waitCycle();
      waitCycle();
      reset = 1'b0;

      $display("[TB] test 1: reset state and single write");
      checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("reset_level", 32'(level), 32'd0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset_almost_full", 32'(almost_full), 32'd0);
      checkOutput("reset_overflow", 32'(overflow_err), 32'd0);

      applyStimulus(1'b1, 8'hA1, 1'b0);
      #1;
      checkOutput("t1_mem_wr_en", 32'(mem_wr_en), 32'd1);
      checkOutput("t1_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
      checkOutput("t1_mem_wr_data", 32'(mem_wr_data), 32'hA1);
      waitCycle();
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("t1_mem_wr_en_off", 32'(mem_wr_en), 32'd0);
      checkOutput("t1_rd_valid_n1", 32'(rd_valid), 32'd0);
      checkOutput("t1_level_n1", 32'(level), 32'd1);
      waitCycle();
      checkOutput("t1_rd_valid_n2", 32'(rd_valid), 32'd1);
      checkOutput("t1_rd_data_n2", 32'(rd_data), 32'hA1);
      checkOutput("t1_level_n2", 32'(level), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitCycle();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t1_drained_level", 32'(level), 32'd0);

      $display("[TB] test 2: fill with rd_ready low");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'(i + 1), 1'b0);
         waitCycle();
         checkOutput("t2_level", 32'(level), 32'(expLvl2[i]));
         checkOutput("t2_almost_full", 32'(almost_full), 32'(expAf2[i]));
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t2_wr_ready_full", 32'(wr_ready), 32'd0);
      checkOutput("t2_overflow", 32'(overflow_err), 32'd1);
      checkOutput("t2_rd_data_head", 32'(rd_data), 32'h01);

      $display("[TB] test 3: drain from full");
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("t3_wr_ready_before", 32'(wr_ready), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         waitCycle();
         checkOutput("t3_level", 32'(level), 32'(5 - k));
         if (k == 1) begin
            checkOutput("t3_wr_ready_after", 32'(wr_ready), 32'd1);
         end
         checkOutput("t3_rd_valid", 32'(rd_valid), (k < 5) ? 32'd1 : 32'd0);
      end

      $display("[TB] test 4: simultaneous streaming");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b1);
         waitCycle();
         checkOutput("t4_level", 32'(level), (i == 0) ? 32'd1 : 32'd2);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (4) waitCycle();
      checkOutput("t4_level_drained", 32'(level), 32'd0);
      checkOutput("t4_wr_ptr", 32'(mem_wr_addr), 32'd2);
      checkOutput("t4_rd_ptr", 32'(mem_rd_addr), 32'd2);

      $display("[TB] test 5: random traffic");
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      waitCycle();
      reset = 1'b0;
      checkOutput("t5_reset_overflow", 32'(overflow_err), 32'd0);
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(($urandom_range(0, 1) == 1) && wr_ready, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 1) == 1));
         waitCycle();
         checkOutput("t5_level", 32'(level), 32'(expQ.size()));
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (8) waitCycle();
      checkOutput("t5_level_drained", 32'(level), 32'd0);
      checkOutput("t5_overflow", 32'(overflow_err), 32'd0);

      $display("[TB] test 6: reset mid-stream");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
         waitCycle();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t6_level_before", 32'(level), 32'd4);
      reset = 1'b1;
      waitCycle();
      reset = 1'b0;
      checkOutput("t6_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("t6_level", 32'(level), 32'd0);
      checkOutput("t6_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("t6_overflow", 32'(overflow_err), 32'd0);
      applyStimulus(1'b1, 8'h5A, 1'b0);
      waitCycle();
      applyStimulus(1'b0, 8'h00, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (rd_valid) begin
            seen = 1'b1;
            checkOutput("t6_rd_data", 32'(rd_data), 32'h5A);
         end else begin
            waitCycle();
         end
      end
      checkOutput("t6_word_seen", 32'(seen), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitCycle();
      applyStimulus(1'b0, 8'h00, 1'b0);
      waitCycle();
      checkOutput("t6_level_end", 32'(level), 32'd0);
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
